ft_out_arbiter: RTL and testbench

- Shares the single byte-wide write port of the FT245 output FIFO between two frame sources.
  - Requester 0: the master response framer.
  - Requester 1: the asynchronous status/interrupt framer.
- Granularity is the whole frame: once a requester is granted, it owns the FIFO until it sends its last byte, so frames never interleave.
- A watchdog reclaims the port from a requester that stalls mid-frame.
- Sits between the host-interface framers and ft245_sync_fifo.

---
 rtl/ft_out_arbiter.sv | 130 +++++++++++++
 tb/tb_ft_out_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_out_arbiter.sv
// ft_out_arbiter: frame-granular two-requester arbiter for the single byte-wide
// write port of the FT245 output FIFO. A granted requester owns the port until
// it sends its last byte or until the watchdog reclaims a stalled grant.
module ft_out_arbiter #(
  parameter logic [15:0] TIMEOUT    = 16'd1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0: master response framer
  input  logic        req0_req,
  output logic        req0_gnt,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  // requester 1: asynchronous status/interrupt framer
  input  logic        req1_req,
  output logic        req1_gnt,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  // FIFO write side
  output logic        out_fifo_wr,
  output logic [7:0]  out_fifo_data,
  input  logic        out_fifo_full,
  // status
  output logic        busy,
  output logic        timeout,
  output logic [15:0] frame_count
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        timeout_q, timeout_d;

  logic        own_valid;
  logic        own_last;
  logic [7:0]  own_data;
  logic        xfer_act;
  logic        wr;

  // Owner-selected byte lane and the zero-latency write path into the FIFO;
  // reset blanks every handshake so nothing is written during rst.
  always_comb begin
    own_valid     = owner_q ? req1_valid : req0_valid;
    own_last      = owner_q ? req1_last  : req0_last;
    own_data      = owner_q ? req1_data  : req0_data;
    xfer_act      = (state_q == XFER) && !rst;
    wr            = xfer_act && own_valid && !out_fifo_full;
    req0_ready    = xfer_act && !owner_q && !out_fifo_full;
    req1_ready    = xfer_act &&  owner_q && !out_fifo_full;
    out_fifo_wr   = wr;
    out_fifo_data = wr ? own_data : 8'h00;
  end

  assign req0_gnt    = (state_q == XFER) && !owner_q;
  assign req1_gnt    = (state_q == XFER) &&  owner_q;
  assign busy        = (state_q == XFER);
  assign timeout     = timeout_q;
  assign frame_count = frame_count_q;

  // Arbitration, end-of-frame bookkeeping and the stall watchdog.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    wd_d          = wd_q;
    frame_count_d = frame_count_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_req || req1_req) begin
          state_d = XFER;
          wd_d    = 16'd0;
          if (req0_req && req1_req)
            owner_d = FIXED_PRIO ? 1'b0 : ~last_owner_q;
          else
            owner_d = req1_req;
        end
      end
      XFER: begin
        if (wr) begin
          wd_d = 16'd0;
          if (own_last) begin
            state_d       = IDLE;
            last_owner_d  = owner_q;
            frame_count_d = frame_count_q + 16'd1;
          end
        end else if (!own_valid) begin
          // Only cycles with nothing offered count; backpressure holds the count.
          if (wd_q == TIMEOUT - 16'd1) begin
            timeout_d    = 1'b1;
            state_d      = IDLE;
            last_owner_d = owner_q;
          end else begin
            wd_d = wd_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; last_owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      wd_q          <= 16'd0;
      frame_count_q <= 16'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wd_q          <= wd_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ft_out_arbiter.sv
// tb_ft_out_arbiter: directed vectors for ft_out_arbiter. Instance A is
// round-robin with the default watchdog, instance B is fixed-priority with a
// short watchdog; both share the stimulus and the observed set is muxed.
module tb_ft_out_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req, r0_valid, r0_last;
  logic [7:0] r0_data;
  logic       r1_req, r1_valid, r1_last;
  logic [7:0] r1_data;
  logic       full;

  logic        a_g0, a_g1, a_rd0, a_rd1, a_wr, a_busy, a_to;
  logic [7:0]  a_dat;
  logic [15:0] a_fc;
  logic        b_g0, b_g1, b_rd0, b_rd1, b_wr, b_busy, b_to;
  logic [7:0]  b_dat;
  logic [15:0] b_fc;

  logic        use_b;
  logic        o_g0, o_g1, o_rd0, o_rd1, o_wr, o_busy, o_to;
  logic [7:0]  o_dat;
  logic [15:0] o_fc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ft_out_arbiter #(.TIMEOUT(16'd1024), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .req0_req(r0_req), .req0_gnt(a_g0), .req0_valid(r0_valid), .req0_data(r0_data),
    .req0_last(r0_last), .req0_ready(a_rd0),
    .req1_req(r1_req), .req1_gnt(a_g1), .req1_valid(r1_valid), .req1_data(r1_data),
    .req1_last(r1_last), .req1_ready(a_rd1),
    .out_fifo_wr(a_wr), .out_fifo_data(a_dat), .out_fifo_full(full),
    .busy(a_busy), .timeout(a_to), .frame_count(a_fc));

  ft_out_arbiter #(.TIMEOUT(16'd8), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_req(r0_req), .req0_gnt(b_g0), .req0_valid(r0_valid), .req0_data(r0_data),
    .req0_last(r0_last), .req0_ready(b_rd0),
    .req1_req(r1_req), .req1_gnt(b_g1), .req1_valid(r1_valid), .req1_data(r1_data),
    .req1_last(r1_last), .req1_ready(b_rd1),
    .out_fifo_wr(b_wr), .out_fifo_data(b_dat), .out_fifo_full(full),
    .busy(b_busy), .timeout(b_to), .frame_count(b_fc));

  assign o_g0   = use_b ? b_g0   : a_g0;
  assign o_g1   = use_b ? b_g1   : a_g1;
  assign o_rd0  = use_b ? b_rd0  : a_rd0;
  assign o_rd1  = use_b ? b_rd1  : a_rd1;
  assign o_wr   = use_b ? b_wr   : a_wr;
  assign o_busy = use_b ? b_busy : a_busy;
  assign o_to   = use_b ? b_to   : a_to;
  assign o_dat  = use_b ? b_dat  : a_dat;
  assign o_fc   = use_b ? b_fc   : a_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    r0_req = 0; r0_valid = 0; r0_last = 0; r0_data = 8'h00;
    r1_req = 0; r1_valid = 0; r1_last = 0; r1_data = 8'h00;
    full = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  // Offer one byte from the owner and expect it to be written this cycle.
  task automatic send_byte(input bit who, input logic [7:0] d, input bit last, input string tag);
    if (who) begin r1_valid = 1; r1_data = d; r1_last = last; end
    else     begin r0_valid = 1; r0_data = d; r0_last = last; end
    settle;
    check({tag, "_wr"}, o_wr, 1'b1);
    check({tag, "_data"}, o_dat, d);
    check({tag, "_rdy"}, who ? o_rd1 : o_rd0, 1'b1);
    check({tag, "_nordy"}, who ? o_rd0 : o_rd1, 1'b0);
    step;
    r0_valid = 0; r0_last = 0; r1_valid = 0; r1_last = 0;
  endtask

  logic [7:0] t1_bytes [5] = '{8'hDC, 8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    int bad_wr, bad_rdy, bad_to, bad_gnt;
    use_b = 1'b0;

    // ---- reset state and single-requester frame ----
    do_reset;
    settle;
    check("rst_gnt0", o_g0, 1'b0);
    check("rst_gnt1", o_g1, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_to", o_to, 1'b0);
    check("rst_fc", o_fc, 16'd0);
    check("rst_wr", o_wr, 1'b0);
    r0_req = 1;
    settle;
    check("t1_gnt_lat0", o_g0, 1'b0);
    step;
    check("t1_gnt", o_g0, 1'b1);
    check("t1_busy", o_busy, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(1'b0, t1_bytes[i], i == 4, "t1_byte");
    r0_req = 0;
    settle;
    check("t1_gnt_drop", o_g0, 1'b0);
    check("t1_fc", o_fc, 16'd1);
    check("t1_idle_data", o_dat, 8'h00);

    // ---- round-robin alternation ----
    do_reset;
    r0_req = 1; r1_req = 1;
    step;
    check("t2_first0", o_g0, 1'b1);
    check("t2_first_not1", o_g1, 1'b0);
    r1_valid = 1; r1_data = 8'hAA; r1_last = 1;
    send_byte(1'b0, 8'h10, 1'b0, "t2_a");
    r1_valid = 1; r1_data = 8'hAA; r1_last = 1;
    send_byte(1'b0, 8'h11, 1'b1, "t2_a");
    settle;
    check("t2_gap_g0", o_g0, 1'b0);
    check("t2_gap_g1", o_g1, 1'b0);
    step;
    check("t2_second1", o_g1, 1'b1);
    send_byte(1'b1, 8'h20, 1'b0, "t2_b");
    send_byte(1'b1, 8'h21, 1'b1, "t2_b");
    check("t2_fc2", o_fc, 16'd2);
    step;
    check("t2_third0", o_g0, 1'b1);
    send_byte(1'b0, 8'h30, 1'b1, "t2_c");
    check("t2_fc3", o_fc, 16'd3);
    r0_req = 0; r1_req = 0;

    // ---- fixed priority, no preemption ----
    use_b = 1'b1;
    do_reset;
    r0_req = 1; r1_req = 1;
    bad_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (o_g1 !== 1'b0) bad_gnt++;
      check("t3_g0", o_g0, 1'b1);
      send_byte(1'b0, 8'h40 + 8'(k), 1'b1, "t3_f");
    end
    check("t3_g1_never", bad_gnt, 0);
    r0_req = 0;
    step;
    check("t3_r1_gnt", o_g1, 1'b1);
    r0_req = 1;
    send_byte(1'b1, 8'h50, 1'b0, "t3_r1");
    settle;
    check("t3_hold1", o_g1, 1'b1);
    check("t3_nopre0", o_g0, 1'b0);
    send_byte(1'b1, 8'h51, 1'b1, "t3_r1");
    step;
    check("t3_back0", o_g0, 1'b1);

    // ---- watchdog (TIMEOUT=8) ----
    do_reset;
    r1_req = 1;
    step;
    check("t4_g1", o_g1, 1'b1);
    send_byte(1'b1, 8'h60, 1'b0, "t4_b");
    r0_req = 1;
    bad_to = 0; bad_gnt = 0;
    for (int k = 0; k < 8; k++) begin
      settle;
      if (o_to !== 1'b0) bad_to++;
      if (o_g1 !== 1'b1) bad_gnt++;
      step;
    end
    check("t4_no_early_to", bad_to, 0);
    check("t4_held", bad_gnt, 0);
    r1_valid = 1; r1_data = 8'h61;
    settle;
    check("t4_to_pulse", o_to, 1'b1);
    check("t4_g1_drop", o_g1, 1'b0);
    check("t4_no_wr", o_wr, 1'b0);
    check("t4_rdy1", o_rd1, 1'b0);
    check("t4_fc", o_fc, 16'd0);
    step;
    r1_valid = 0;
    settle;
    check("t4_to_once", o_to, 1'b0);
    check("t4_g0_next", o_g0, 1'b1);
    r0_req = 0; r1_req = 0;

    // ---- backpressure never times out ----
    use_b = 1'b0;
    do_reset;
    r0_req = 1;
    step;
    send_byte(1'b0, 8'h70, 1'b0, "t5_a");
    full = 1; r0_valid = 1; r0_data = 8'h55; r0_last = 1;
    bad_wr = 0; bad_rdy = 0; bad_to = 0; bad_gnt = 0;
    for (int k = 0; k < 2000; k++) begin
      settle;
      if (o_wr !== 1'b0) bad_wr++;
      if (o_rd0 !== 1'b0) bad_rdy++;
      if (o_to !== 1'b0) bad_to++;
      if (o_g0 !== 1'b1) bad_gnt++;
      step;
    end
    check("t5_no_wr", bad_wr, 0);
    check("t5_no_rdy", bad_rdy, 0);
    check("t5_no_to", bad_to, 0);
    check("t5_gnt_held", bad_gnt, 0);
    full = 0;
    send_byte(1'b0, 8'h55, 1'b1, "t5_resume");
    settle;
    check("t5_fc", o_fc, 16'd1);
    check("t5_done", o_g0, 1'b0);

    // ---- reset mid-frame ----
    do_reset;
    r0_req = 1;
    step;
    send_byte(1'b0, 8'h80, 1'b1, "t6_a");
    step;
    check("t6_regnt", o_g0, 1'b1);
    send_byte(1'b0, 8'h81, 1'b0, "t6_b");
    rst = 1; r0_valid = 1; r0_data = 8'h82;
    settle;
    check("t6_rst_wr", o_wr, 1'b0);
    check("t6_rst_rdy", o_rd0, 1'b0);
    step;
    rst = 0; r0_valid = 0; r0_req = 0; r1_req = 1;
    settle;
    check("t6_g0", o_g0, 1'b0);
    check("t6_busy", o_busy, 1'b0);
    check("t6_wr", o_wr, 1'b0);
    check("t6_fc", o_fc, 16'd0);
    check("t6_to", o_to, 1'b0);
    step;
    check("t6_g1", o_g1, 1'b1);
    send_byte(1'b1, 8'h90, 1'b1, "t6_c");
    settle;
    check("t6_fc1", o_fc, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
